// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared types and constants for the 64-bit bitwise logic unit.
//   - DATA_W / POPCNT_W : datapath and population-count widths
//   - op_e              : 3-bit operation select (OP_AND..OP_ANDN)
//   - lu_req_t          : one sampled input beat (valid, op, operands)
//   - lu_op()           : the combinational bitwise operation mux
package logic_unit_pkg;

  localparam int DATA_W   = 64;
  localparam int POPCNT_W = 7;   // 0..64 needs 7 bits

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,   // ~a, b ignored
    OP_ANDN = 3'd7    // a & ~b
  } op_e;

  typedef struct packed {
    logic              vld;
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } lu_req_t;

  // All eight encodings are covered; the default arm only exists so that an
  // X on sel resolves to a defined value instead of propagating.
  function automatic logic [DATA_W-1:0] lu_op(input op_e op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_ANDN: r = a & ~b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_popcnt.sv
// logic_unit_popcnt
//   Combinational population count of a DATA_W-bit vector.
//   The vector is split into NUM_LANES lanes of VEC_W bits; each lane counts
//   locally and the lane counts are summed.
// Ports:
//   vec  in   DATA_W    vector to count
//   cnt  out  POPCNT_W  number of set bits, 0..DATA_W
module logic_unit_popcnt
  import logic_unit_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int VEC_W     = DATA_W / NUM_LANES
) (
  input  logic [DATA_W-1:0]   vec,
  output logic [POPCNT_W-1:0] cnt
);

  localparam int LANE_CW = $clog2(VEC_W + 1);

  logic [NUM_LANES-1:0][VEC_W-1:0]   lane_vec;
  logic [NUM_LANES-1:0][LANE_CW-1:0] lane_cnt;

  assign lane_vec = vec;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_comb begin
      lane_cnt[l] = '0;
      for (int i = 0; i < VEC_W; i++)
        lane_cnt[l] = lane_cnt[l] + LANE_CW'(lane_vec[l][i]);
    end
  end

  always_comb begin
    cnt = '0;
    for (int l = 0; l < NUM_LANES; l++)
      cnt = cnt + POPCNT_W'(lane_cnt[l]);
  end

endmodule

// File: rtl/logic_unit.sv
// logic_unit
//   64-bit bitwise logic unit: combinational op mux, one output register
//   stage, throughput one result per cycle, no backpressure.
//   Optional status flags are built when LOGIC_UNIT_FLAGS_EN is defined.
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset (wins over in_valid)
//   in_valid   in   1   qualifies in_0/in_1/sel this cycle
//   in_0       in   64  operand A
//   in_1       in   64  operand B
//   sel        in   3   op select (see op_e)
//   out        out  64  registered result, holds when no new input
//   out_valid  out  1   one-cycle pulse per new result
//   LOGIC_UNIT_FLAGS_EN only (registered alongside out):
//   zero/ones/parity out 1, popcnt out 7
module logic_unit
  import logic_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_0,
  input  logic [DATA_W-1:0]   in_1,
  input  logic [2:0]          sel,
  output logic [DATA_W-1:0]   out,
  output logic                out_valid
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic                zero,
  output logic                ones,
  output logic                parity,
  output logic [POPCNT_W-1:0] popcnt
`endif
);

  localparam int STAGES = 1;

  lu_req_t           req;
  logic [DATA_W-1:0] res;
  logic [STAGES:0]   vld_pipe;

  assign req = '{vld: in_valid, op: op_e'(sel), a: in_0, b: in_1};
  assign res = lu_op(req.op, req.a, req.b);

  // Valid shift register; bit 0 is the live input, bit STAGES is out_valid.
  assign vld_pipe[0] = req.vld;
  for (genvar s = 0; s < STAGES; s++) begin : g_vld
    always_ff @(posedge clk) begin
      if (rst) vld_pipe[s+1] <= 1'b0;
      else     vld_pipe[s+1] <= vld_pipe[s];
    end
  end
  assign out_valid = vld_pipe[STAGES];

  // Data only loads on a valid beat so out holds between results.
  always_ff @(posedge clk) begin
    if (rst)          out <= '0;
    else if (req.vld) out <= res;
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic [POPCNT_W-1:0] res_cnt;

  logic_unit_popcnt u_popcnt (
    .vec (res),
    .cnt (res_cnt)
  );

  // Reset values describe out == 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero   <= 1'b1;
      ones   <= 1'b0;
      parity <= 1'b0;
      popcnt <= '0;
    end else if (req.vld) begin
      zero   <= ~|res;
      ones   <= &res;
      parity <= ^res;
      popcnt <= res_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit.sv
module tb_logic_unit;
  import logic_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_0 = '0;
  logic [63:0] in_1 = '0;
  logic [2:0]  sel = '0;
  logic [63:0] out;
  logic        out_valid;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        zero, ones, parity;
  logic [6:0]  popcnt;
`endif

  logic_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_0      (in_0),
    .in_1      (in_1),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .zero      (zero),
    .ones      (ones),
    .parity    (parity),
    .popcnt    (popcnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [63:0] m_out;
  logic        m_vld;

  // Each op as a truth table over the bit pair {a,b} (index 0=00 .. 3=11).
  function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic [2:0] s);
    logic [3:0]  lut;
    logic [63:0] r;
    case (s)
      3'd0:    lut = 4'b1000;
      3'd1:    lut = 4'b1110;
      3'd2:    lut = 4'b0110;
      3'd3:    lut = 4'b0111;
      3'd4:    lut = 4'b0001;
      3'd5:    lut = 4'b1001;
      3'd6:    lut = 4'b0011;
      default: lut = 4'b0100;
    endcase
    for (int i = 0; i < 64; i++) r[i] = lut[{a[i], b[i]}];
    return r;
  endfunction

  function automatic int ref_pop(input logic [63:0] v);
    int c = 0;
    for (int i = 0; i < 64; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one beat at the falling edge, clock it, update the model, then
  // compare everything at the next falling edge.
  task automatic cycle(input logic r, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] s);
    rst = r; in_valid = v; in_0 = a; in_1 = b; sel = s;
    @(posedge clk);
    if (r)      begin m_out = '0; m_vld = 1'b0; end
    else if (v) begin m_out = ref_op(a, b, s); m_vld = 1'b1; end
    else        m_vld = 1'b0;
    @(negedge clk);
    check("out", out, m_out);
    check("out_valid", 64'(out_valid), 64'(m_vld));
`ifdef LOGIC_UNIT_FLAGS_EN
    check("zero", 64'(zero), 64'(m_out == 64'd0));
    check("ones", 64'(ones), 64'(m_out == {64{1'b1}}));
    check("parity", 64'(parity), 64'(ref_pop(m_out) % 2));
    check("popcnt", 64'(popcnt), 64'(ref_pop(m_out)));
`endif
  endtask

  logic [63:0] exp28 [8];
  logic [63:0] held;
  int          pulses;

  initial begin
    exp28 = '{64'hF000F000F000F000, 64'hFFF0FFF0FFF0FFF0, 64'h0FF00FF00FF00FF0,
              64'h0FFF0FFF0FFF0FFF, 64'h000F000F000F000F, 64'hF00FF00FF00FF00F,
              64'h0F0F0F0F0F0F0F0F, 64'h00F000F000F000F0};

    // Reset with a valid all-ones input pending: input must be discarded.
    cycle(1'b1, 1'b1, '1, '1, 3'd1);
    check("rst_out", out, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("rst_zero", 64'(zero), 64'd1);
`endif
    cycle(1'b1, 1'b0, '0, '0, 3'd0);

    // Sel sweep, back-to-back valid beats straight after reset.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 3'(i));
      check($sformatf("sweep_sel%0d", i), out, exp28[i]);
      check($sformatf("sweep_vld%0d", i), 64'(out_valid), 64'd1);
    end

    // Hold: one valid beat then three idle beats with changing operands.
    cycle(1'b0, 1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 3'd2);
    held   = 64'h0123456789ABCDEF ^ 64'hFEDCBA9876543210;
    pulses = int'(out_valid);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
      pulses += int'(out_valid);
    end
    check("hold_out", out, held);
    check("hold_pulses", 64'(pulses), 64'd1);

`ifdef LOGIC_UNIT_FLAGS_EN
    cycle(1'b0, 1'b1, '1, '1, 3'd1);
    check("flag_ones", 64'(ones), 64'd1);
    check("flag_pop64", 64'(popcnt), 64'd64);
    check("flag_par0", 64'(parity), 64'd0);
    check("flag_zero0", 64'(zero), 64'd0);
    cycle(1'b0, 1'b1, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 3'd2);
    check("flag_zero1", 64'(zero), 64'd1);
    check("flag_pop0", 64'(popcnt), 64'd0);
`endif

    // Random regression, with occasional resets mixed in.
    for (int n = 0; n < 1000; n++)
      cycle($urandom_range(0, 49) == 0, 1'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, 3'($urandom));

    // First valid after a reset is processed normally.
    cycle(1'b1, 1'b0, '0, '0, 3'd0);
    cycle(1'b0, 1'b1, 64'hAAAA5555AAAA5555, 64'h0F0F0F0F0F0F0F0F, 3'd7);
    check("post_rst_first", out, 64'hA0A05050A0A05050);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
